// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS core: opcodes, control FSM state
// encodings and datapath mux select codes.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JEX     = 4'd11
  } state_e;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] ALUSRCB_B     = 2'b00;
  localparam logic [1:0] ALUSRCB_FOUR  = 2'b01;
  localparam logic [1:0] ALUSRCB_IMM   = 2'b10;
  localparam logic [1:0] ALUSRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multicycle controller and the shared datapath.
// The datapath side is the master (supplies opcode and zero flag).
interface multicycle_ctrl_if;
  logic [5:0] op;
  logic       zero;
  logic       pcen;
  logic       iord;
  logic       memwrite;
  logic       irwrite;
  logic       regdst;
  logic       memtoreg;
  logic       regwrite;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [1:0] aluop;
  logic [1:0] pcsrc;
  logic [3:0] state;

  modport master (
    output op, zero,
    input  pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite,
           alusrca, alusrcb, aluop, pcsrc, state
  );

  modport slave (
    input  op, zero,
    output pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite,
           alusrca, alusrcb, aluop, pcsrc, state
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle MIPS core: a Moore machine stepping the
// shared datapath, with a wait counter that stretches the memory states.
module multicycle_ctrl
  import mips_pkg::*;
#(
  parameter int unsigned MEM_WAIT = 0
) (
  input logic              clk,
  input logic              rst,
  multicycle_ctrl_if.slave bus
);

  localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT);

  state_e     state_q, state_d;
  logic [3:0] waitCnt_q, waitCnt_d;
  logic       waitDone;
  logic       pcwrite;
  logic       branch;

  assign waitDone = (waitCnt_q == WAIT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_FETCH;
      waitCnt_q <= '0;
    end else begin
      state_q   <= state_d;
      waitCnt_q <= waitCnt_d;
    end
  end

  // The counter only runs while parked in a memory state; every exit clears it.
  always_comb begin
    state_d   = S_FETCH;
    waitCnt_d = '0;
    case (state_q)
      S_FETCH: begin
        if (waitDone) state_d = S_DECODE;
        else begin
          state_d   = S_FETCH;
          waitCnt_d = waitCnt_q + 4'd1;
        end
      end
      S_DECODE: begin
        case (bus.op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_RTYPEEX;
          OP_BEQ:       state_d = S_BEQEX;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JEX;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR:  state_d = (bus.op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD: begin
        if (waitDone) state_d = S_MEMWB;
        else begin
          state_d   = S_MEMRD;
          waitCnt_d = waitCnt_q + 4'd1;
        end
      end
      S_MEMWR: begin
        if (waitDone) state_d = S_FETCH;
        else begin
          state_d   = S_MEMWR;
          waitCnt_d = waitCnt_q + 4'd1;
        end
      end
      S_RTYPEEX: state_d = S_RTYPEWB;
      S_ADDIEX:  state_d = S_ADDIWB;
      default:   state_d = S_FETCH;
    endcase
  end

  always_comb begin
    pcwrite      = 1'b0;
    branch       = 1'b0;
    bus.iord     = 1'b0;
    bus.memwrite = 1'b0;
    bus.irwrite  = 1'b0;
    bus.regdst   = 1'b0;
    bus.memtoreg = 1'b0;
    bus.regwrite = 1'b0;
    bus.alusrca  = 1'b0;
    bus.alusrcb  = ALUSRCB_B;
    bus.aluop    = ALUOP_ADD;
    bus.pcsrc    = PCSRC_ALU;
    case (state_q)
      S_FETCH: begin
        bus.alusrcb = ALUSRCB_FOUR;
        bus.pcsrc   = PCSRC_ALU;
        bus.irwrite = waitDone;
        pcwrite     = waitDone;
      end
      S_DECODE:  bus.alusrcb = ALUSRCB_IMMSH;
      S_MEMADR: begin
        bus.alusrca = 1'b1;
        bus.alusrcb = ALUSRCB_IMM;
      end
      S_MEMRD:   bus.iord = 1'b1;
      S_MEMWB: begin
        bus.memtoreg = 1'b1;
        bus.regwrite = 1'b1;
      end
      S_MEMWR: begin
        bus.iord     = 1'b1;
        bus.memwrite = 1'b1;
      end
      S_RTYPEEX: begin
        bus.alusrca = 1'b1;
        bus.aluop   = ALUOP_FUNCT;
      end
      S_RTYPEWB: begin
        bus.regdst   = 1'b1;
        bus.regwrite = 1'b1;
      end
      S_BEQEX: begin
        bus.alusrca = 1'b1;
        bus.aluop   = ALUOP_SUB;
        bus.pcsrc   = PCSRC_ALUOUT;
        branch      = 1'b1;
      end
      S_ADDIEX: begin
        bus.alusrca = 1'b1;
        bus.alusrcb = ALUSRCB_IMM;
      end
      S_ADDIWB:  bus.regwrite = 1'b1;
      S_JEX: begin
        bus.pcsrc = PCSRC_JUMP;
        pcwrite   = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.pcen  = pcwrite | (branch & bus.zero);
  assign bus.state = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized scoreboard bench for multicycle_ctrl, run with MEM_WAIT=0 and
// MEM_WAIT=2 side by side; expectations come from per-instruction step lists.
module tb_multicycle_ctrl;

  localparam logic [5:0] LW   = 6'b100011;
  localparam logic [5:0] SW   = 6'b101011;
  localparam logic [5:0] RT   = 6'b000000;
  localparam logic [5:0] BEQ  = 6'b000100;
  localparam logic [5:0] ADDI = 6'b001000;
  localparam logic [5:0] JMP  = 6'b000010;

  typedef struct {
    logic [17:0] vec;
    string       what;
  } exp_t;

  logic clk = 1'b0;
  logic rst0, rst1;
  exp_t q0[$];
  exp_t q1[$];
  int   checks   = 0;
  int   failures = 0;
  bit   done0    = 1'b0;
  bit   done1    = 1'b0;
  logic [17:0] got0, got1;

  always #5 clk = ~clk;

  multicycle_ctrl_if bus0 ();
  multicycle_ctrl_if bus1 ();

  multicycle_ctrl #(.MEM_WAIT(0)) dut0 (.clk(clk), .rst(rst0), .bus(bus0));
  multicycle_ctrl #(.MEM_WAIT(2)) dut1 (.clk(clk), .rst(rst1), .bus(bus1));

  assign got0 = {bus0.pcen, bus0.iord, bus0.memwrite, bus0.irwrite, bus0.regdst,
                 bus0.memtoreg, bus0.regwrite, bus0.alusrca, bus0.alusrcb,
                 bus0.aluop, bus0.pcsrc, bus0.state};
  assign got1 = {bus1.pcen, bus1.iord, bus1.memwrite, bus1.irwrite, bus1.regdst,
                 bus1.memtoreg, bus1.regwrite, bus1.alusrca, bus1.alusrcb,
                 bus1.aluop, bus1.pcsrc, bus1.state};

  // Output table: what each named step of an instruction must drive.
  function automatic logic [17:0] specOutputs(int st, bit lastWait, logic z);
    logic       pcen = 0, iord = 0, memwrite = 0, irwrite = 0, regdst = 0;
    logic       memtoreg = 0, regwrite = 0, alusrca = 0;
    logic [1:0] alusrcb = 2'b00, aluop = 2'b00, pcsrc = 2'b00;
    case (st)
      0:  begin alusrcb = 2'b01; irwrite = lastWait; pcen = lastWait; end
      1:  alusrcb = 2'b11;
      2:  begin alusrca = 1; alusrcb = 2'b10; end
      3:  iord = 1;
      4:  begin memtoreg = 1; regwrite = 1; end
      5:  begin iord = 1; memwrite = 1; end
      6:  begin alusrca = 1; aluop = 2'b10; end
      7:  begin regdst = 1; regwrite = 1; end
      8:  begin alusrca = 1; aluop = 2'b01; pcsrc = 2'b01; pcen = z; end
      9:  begin alusrca = 1; alusrcb = 2'b10; end
      10: regwrite = 1;
      11: begin pcsrc = 2'b10; pcen = 1; end
      default: ;
    endcase
    return {pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
            alusrcb, aluop, pcsrc, 4'(st)};
  endfunction

  // Step list for one instruction: each entry is state*2 + lastWaitCycle.
  function automatic void buildSteps(input logic [5:0] op, input int w, output int steps[$]);
    steps = {};
    for (int i = 0; i <= w; i++) steps.push_back(0 * 2 + ((i == w) ? 1 : 0));
    steps.push_back(1 * 2);
    case (op)
      LW: begin
        steps.push_back(2 * 2);
        for (int i = 0; i <= w; i++) steps.push_back(3 * 2);
        steps.push_back(4 * 2);
      end
      SW: begin
        steps.push_back(2 * 2);
        for (int i = 0; i <= w; i++) steps.push_back(5 * 2);
      end
      RT:      begin steps.push_back(6 * 2); steps.push_back(7 * 2); end
      BEQ:     steps.push_back(8 * 2);
      ADDI:    begin steps.push_back(9 * 2); steps.push_back(10 * 2); end
      JMP:     steps.push_back(11 * 2);
      default: ;
    endcase
  endfunction

  task automatic pushExp(int lane, int st, bit lastWait, logic z, string what);
    exp_t e;
    e.vec  = specOutputs(st, lastWait, z);
    e.what = what;
    if (lane == 0) q0.push_back(e);
    else           q1.push_back(e);
  endtask

  task automatic setInputs(int lane, logic [5:0] op, logic z);
    if (lane == 0) begin bus0.op = op; bus0.zero = z; end
    else           begin bus1.op = op; bus1.zero = z; end
  endtask

  task automatic setRst(int lane, logic v);
    if (lane == 0) rst0 = v;
    else           rst1 = v;
  endtask

  // Runs one instruction from the start of FETCH; abortAt pulses reset on that step.
  task automatic applyStimulus(int lane, logic [5:0] op, int abortAt);
    int   steps[$];
    int   w;
    logic z;
    w = (lane == 0) ? 0 : 2;
    buildSteps(op, w, steps);
    foreach (steps[i]) begin
      z = 1'($urandom_range(0, 1));
      setInputs(lane, op, z);
      if (i == abortAt) begin
        setRst(lane, 1'b1);
        pushExp(lane, 0, (w == 0), z,
                $sformatf("lane%0d op=%b abort_step=%0d", lane, op, i));
        @(posedge clk); #1;
        setRst(lane, 1'b0);
        return;
      end
      pushExp(lane, steps[i] / 2, bit'(steps[i] % 2), z,
              $sformatf("lane%0d op=%b step=%0d state=%0d", lane, op, i, steps[i] / 2));
      @(posedge clk); #1;
    end
  endtask

  task automatic runLane(int lane);
    logic [5:0] op;
    int         w;
    int         pick;
    w = (lane == 0) ? 0 : 2;
    setRst(lane, 1'b1);
    setInputs(lane, 6'b0, 1'b0);
    @(posedge clk); #1;
    repeat (2) begin
      pushExp(lane, 0, (w == 0), 1'b0, $sformatf("lane%0d reset", lane));
      @(posedge clk); #1;
    end
    setRst(lane, 1'b0);
    applyStimulus(lane, LW, 2 * w + 4);
    applyStimulus(lane, LW, -1);
    applyStimulus(lane, SW, -1);
    applyStimulus(lane, RT, -1);
    applyStimulus(lane, BEQ, -1);
    applyStimulus(lane, BEQ, -1);
    applyStimulus(lane, ADDI, -1);
    applyStimulus(lane, JMP, -1);
    applyStimulus(lane, 6'b111111, -1);
    repeat (40) begin
      pick = $urandom_range(0, 6);
      case (pick)
        0: op = LW;
        1: op = SW;
        2: op = RT;
        3: op = BEQ;
        4: op = ADDI;
        5: op = JMP;
        default: begin
          do op = 6'($urandom);
          while (op inside {LW, SW, RT, BEQ, ADDI, JMP});
        end
      endcase
      applyStimulus(lane, op, ($urandom_range(0, 9) == 0) ? $urandom_range(0, 8) : -1);
    end
  endtask

  task automatic checkOutput(logic [17:0] got, exp_t e);
    checks++;
    if (got !== e.vec) begin
      failures++;
      $display("[TB] FAIL %s got=%b want=%b", e.what, got, e.vec);
    end
  endtask

  // Monitor: every cycle the DUT presents a Moore output, compared at the falling edge.
  always @(negedge clk) begin
    if (q0.size() > 0) checkOutput(got0, q0.pop_front());
    if (q1.size() > 0) checkOutput(got1, q1.pop_front());
  end

  initial begin
    runLane(0);
    done0 = 1'b1;
  end

  initial begin
    runLane(1);
    done1 = 1'b1;
  end

  initial begin
    wait (done0 && done1);
    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
